wrr_scheduler_ctrl: RTL and testbench
=====================================

Name: wrr_scheduler_ctrl

Overview:
- Weighted round-robin controller that shares one DATA_WIDTH output channel between N_INPUTS requesters.
- Each requester has a valid/ready port. On a grant, the block passes up to weight[i] beats from the granted input, then rotates priority to the next input.
- Sits in front of the scheduler datapath. It feeds that datapath from packed requester buses, in the same packed format as r_in.

Parameters:
- DATA_WIDTH, 16, width of one data beat.
- N_INPUTS, 4, number of requesters (>=2).
- WEIGHT_WIDTH, 4, width of each per-input burst weight.
- ID_WIDTH, $clog2(N_INPUTS), width of grant_id.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset (rst==0 resets immediately, independent of clk).
- req_valid  input  N_INPUTS  per-requester beat valid; bit i is requester i.
- req_data  input  N_INPUTS*DATA_WIDTH  packed beats; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  N_INPUTS  per-requester accept; at most one bit high.
- weights  input  N_INPUTS*WEIGHT_WIDTH  packed burst limits; field i sampled at grant start.
- out_valid  output  1  output beat valid.
- out_data  output  DATA_WIDTH  output beat.
- out_ready  input  1  downstream accept.
- out_last  output  1  high with the final beat of a burst (credit exhausted).
- grant_id  output  ID_WIDTH  index of the current grantee; 0 when idle.
- busy  output  1  high in GRANT state.

Behaviour:
- Reset (rst low, asynchronous), then held until rst returns high:
  - state=IDLE, rr_ptr=0, credit=0, grant_id=0.
  - req_ready=0, out_valid=0, out_data=0, out_last=0, busy=0.
- Reset mid-burst aborts the burst. No beat is transferred in the reset cycle.
- State IDLE:
  - Scan req_valid circularly starting at rr_ptr. Pick the first set bit g.
  - If found, at the next posedge: grant_id<=g, credit<=weights[g], state<=GRANT.
  - A weight of 0 is treated as 1.
  - If nothing is found, stay in IDLE.
  - req_ready=0 and out_valid=0 throughout IDLE, giving a one-cycle arbitration bubble.
- State GRANT (g = grant_id), combinational pass-through:
  - out_valid = req_valid[g]; out_data = req_data[g].
  - req_ready[g] = out_ready; all other req_ready bits = 0.
  - out_last = out_valid && credit==1.
  - out_data = 0 when out_valid is 0.
- Beat transfer: occurs when req_valid[g] && out_ready. Each transfer does credit<=credit-1.
- Release: leave GRANT for IDLE with rr_ptr<=(g+1) mod N_INPUTS when either:
  - (a) a transfer occurs with credit==1, or
  - (b) req_valid[g]==0 in GRANT (the requester ran dry; its unused credit is forfeited).
- Backpressure: out_ready low with req_valid[g] high holds the beat. Credit does not change and the grant is kept indefinitely.
- rr_ptr wrap: after granting N_INPUTS-1, rr_ptr=0.
- A requester that is granted and keeps requesting is not re-granted until every other valid requester has had a turn.
- weights changing during a burst have no effect until the next grant.
- Throughput: the maximum number of beats per grant is 2^WEIGHT_WIDTH-1, followed by one idle cycle per grant.
- No combinational path from out_ready to out_valid.

Test Plan:
- Reset: rst=0 at random point mid-burst -> all outputs 0 immediately, grant_id=0; after release with req_valid=4'b0000 the block stays idle.
- Rotation:
  - Stimulus: req_valid=4'b1111, weights all 1, req_data=64'haaaa_bbbb_cccc_dddd, out_ready=1.
  - Required: out_data sequence dddd,cccc,bbbb,aaaa,dddd…, each followed by a bubble; out_last on every beat; grant_id 0,1,2,3,0.
- Weights:
  - Stimulus: weights={4'd0,4'd1,4'd2,4'd3} (input0=3, input1=2, input2=1, input3=0), all valid.
  - Required: 3 beats from 0, then 2 from 1, then 1 from 2, then 1 from 3 (weight 0 treated as 1); out_last only on each burst's final beat.
- Backpressure: input1 alone valid, weight 2; out_ready low for 5 cycles mid-burst -> out_valid held, req_ready[1]=0, credit frozen, exactly 2 beats total.
- Early drop: input2 weight 5 drops req_valid after 2 beats -> returns to IDLE; next grant goes to input 3 if valid, else wraps to 0.
- Skip idle: req_valid=4'b1001, rr_ptr=1 -> grant input 3, then input 0, then input 3; inputs 1 and 2 never see req_ready.

Source files
------------

// File: rtl/wrr_scheduler_ctrl.sv
// Weighted round-robin controller: shares one output channel between N_INPUTS
// valid/ready requesters. A grant passes up to weight[g] beats (0 counts as 1),
// then priority rotates to the input after the grantee.
module wrr_scheduler_ctrl #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned N_INPUTS     = 4,
    parameter int unsigned WEIGHT_WIDTH = 4,
    parameter int unsigned ID_WIDTH     = $clog2(N_INPUTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_INPUTS-1:0]              req_valid,
    input  logic [N_INPUTS*DATA_WIDTH-1:0]   req_data,
    output logic [N_INPUTS-1:0]              req_ready,
    input  logic [N_INPUTS*WEIGHT_WIDTH-1:0] weights,
    output logic                             out_valid,
    output logic [DATA_WIDTH-1:0]            out_data,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic [ID_WIDTH-1:0]              grant_id,
    output logic                             busy
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e                  state_q, state_d;
    logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]     grant_q, grant_d;
    logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

    logic [2*N_INPUTS-1:0]   rot;
    int                      pick_sum;
    logic                    found;
    logic [ID_WIDTH-1:0]     pick;
    logic [WEIGHT_WIDTH-1:0] pick_weight;
    logic                    g_valid;
    logic [DATA_WIDTH-1:0]   g_data;
    logic                    last_credit;
    logic [ID_WIDTH-1:0]     next_ptr;

    // Circular scan of req_valid starting at rr_ptr; first set bit wins
    always_comb begin
        rot      = {req_valid, req_valid} >> rr_ptr_q;
        found    = 1'b0;
        pick     = '0;
        pick_sum = 0;
        for (int k = 0; k < int'(N_INPUTS); k++) begin
            if (!found && rot[k]) begin
                found    = 1'b1;
                pick_sum = int'(rr_ptr_q) + k;
                if (pick_sum >= int'(N_INPUTS)) begin
                    pick_sum = pick_sum - int'(N_INPUTS);
                end
                pick = ID_WIDTH'(pick_sum);
            end
        end
    end

    // Per-input field selection for the scan winner and the current grantee
    always_comb begin
        pick_weight = '0;
        g_valid     = 1'b0;
        g_data      = '0;
        for (int i = 0; i < int'(N_INPUTS); i++) begin
            if (pick == ID_WIDTH'(i)) begin
                pick_weight = weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
            if (grant_q == ID_WIDTH'(i)) begin
                g_valid = req_valid[i];
                g_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign last_credit = (credit_q == WEIGHT_WIDTH'(1));
    assign next_ptr    = (grant_q == ID_WIDTH'(N_INPUTS - 1)) ? '0 : grant_q + ID_WIDTH'(1);
    assign grant_id    = grant_q;

    // Next-state and pass-through outputs; idle cycle doubles as arbitration bubble
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        credit_d  = credit_q;
        req_ready = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d  = pick;
                    credit_d = (pick_weight == '0) ? WEIGHT_WIDTH'(1) : pick_weight;
                    state_d  = StGrant;
                end
            end
            StGrant: begin
                busy      = 1'b1;
                out_valid = g_valid;
                out_data  = g_valid ? g_data : '0;
                out_last  = g_valid && last_credit;
                for (int i = 0; i < int'(N_INPUTS); i++) begin
                    req_ready[i] = (grant_q == ID_WIDTH'(i)) && out_ready;
                end
                // Release on the final credited transfer or when the grantee runs dry
                if (!g_valid || (out_ready && last_credit)) begin
                    state_d  = StIdle;
                    rr_ptr_d = next_ptr;
                    grant_d  = '0;
                    credit_d = '0;
                end else if (out_ready) begin
                    credit_d = credit_q - WEIGHT_WIDTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            credit_q <= credit_d;
        end
    end

endmodule

// File: tb/tb_wrr_scheduler_ctrl.sv
// Self-checking bench for wrr_scheduler_ctrl: directed scenarios plus randomized
// traffic compared against a transaction-level weighted round-robin model.
module tb_wrr_scheduler_ctrl;

    localparam int DW = 16;
    localparam int N  = 4;
    localparam int WW = 4;
    localparam int IW = 2;
    localparam int OW = 1 + IW + 1 + 1 + N + DW;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [N*WW-1:0] weights;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_ready;
    logic            out_last;
    logic [IW-1:0]   grant_id;
    logic            busy;

    int errors = 0;
    int checks = 0;

    logic [OW-1:0] obs;
    assign obs = {busy, grant_id, out_valid, out_last, req_ready, out_data};

    logic [DW-1:0] q_data[$];
    int            q_gid[$];
    logic          q_last[$];

    wrr_scheduler_ctrl #(
        .DATA_WIDTH  (DW),
        .N_INPUTS    (N),
        .WEIGHT_WIDTH(WW),
        .ID_WIDTH    (IW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .weights  (weights),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .out_last (out_last),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference model: who holds the grant, how many beats it may still send,
    // and where the next search starts.
    bit m_busy;
    int m_gid, m_credit, m_ptr, m_i, m_w;
    bit m_found;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 0; m_gid = 0; m_credit = 0; m_ptr = 0;
        end else if (!m_busy) begin
            m_found = 0;
            for (int k = 0; k < N; k++) begin
                m_i = (m_ptr + k) % N;
                if (!m_found && req_valid[m_i]) begin
                    m_found  = 1;
                    m_busy   = 1;
                    m_gid    = m_i;
                    m_w      = int'(weights[m_i*WW +: WW]);
                    m_credit = (m_w == 0) ? 1 : m_w;
                end
            end
        end else if (!req_valid[m_gid]) begin
            m_busy = 0; m_ptr = (m_gid + 1) % N;
        end else if (out_ready) begin
            m_credit = m_credit - 1;
            if (m_credit == 0) begin
                m_busy = 0; m_ptr = (m_gid + 1) % N;
            end
        end
    end

    function automatic logic [OW-1:0] model_out();
        logic          ov, ol;
        logic [DW-1:0] od;
        logic [N-1:0]  rr;
        ov = m_busy && req_valid[m_gid];
        od = ov ? req_data[m_gid*DW +: DW] : '0;
        rr = '0;
        if (m_busy) rr[m_gid] = out_ready;
        ol = ov && (m_credit == 1);
        return {m_busy, IW'(m_busy ? m_gid : 0), ov, ol, rr, od};
    endfunction

    task automatic do_reset();
        rst = 1'b0; req_valid = '0; req_data = '0; weights = '0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        q_data.delete(); q_gid.delete(); q_last.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = '0; req_data = '0; weights = '0; out_ready = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++; $display("FAIL reset_initial: got %h want 0", obs);
        end
        @(posedge clk); #1; rst = 1'b1;
        // Mid-burst: long burst from input 0, then pull reset between edges
        req_valid = 4'b1111; weights = 16'hffff; req_data = 64'h1111_2222_3333_4444;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== model_out()) begin
                errors++; $display("FAIL reset_preburst c%0d: got %h want %h", c, obs, model_out());
            end
            @(posedge clk); #1;
        end
        #3 rst = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++; $display("FAIL reset_midburst: got %h want 0", obs);
        end
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== '0) begin
                errors++; $display("FAIL reset_idle c%0d: got %h want 0", c, obs);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rotation();
        logic [DW-1:0] exp_d[5] = '{16'hdddd, 16'hcccc, 16'hbbbb, 16'haaaa, 16'hdddd};
        int            exp_g[5] = '{0, 1, 2, 3, 0};
        do_reset();
        req_valid = 4'b1111; weights = 16'h1111; req_data = 64'haaaa_bbbb_cccc_dddd;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== model_out()) begin
                errors++; $display("FAIL rotation c%0d: got %h want %h", c, obs, model_out());
            end
            if (out_valid && out_ready) begin
                q_data.push_back(out_data); q_gid.push_back(int'(grant_id));
                q_last.push_back(out_last);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (q_data.size() != 5) begin
            errors++; $display("FAIL rotation_count: got %0d want 5", q_data.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if ({q_data[i], q_gid[i], q_last[i]} !== {exp_d[i], exp_g[i], 1'b1}) begin
                    errors++;
                    $display("FAIL rotation_beat%0d: got %h/id%0d/last%0b want %h/id%0d/last1",
                             i, q_data[i], q_gid[i], q_last[i], exp_d[i], exp_g[i]);
                end
            end
        end
    endtask

    task automatic test_weights();
        logic [DW-1:0] exp_d[7] = '{16'hdddd, 16'hdddd, 16'hdddd, 16'hcccc, 16'hcccc,
                                    16'hbbbb, 16'haaaa};
        int            exp_g[7] = '{0, 0, 0, 1, 1, 2, 3};
        logic          exp_l[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        req_valid = 4'b1111; weights = {4'd0, 4'd1, 4'd2, 4'd3};
        req_data = 64'haaaa_bbbb_cccc_dddd; out_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== model_out()) begin
                errors++; $display("FAIL weights c%0d: got %h want %h", c, obs, model_out());
            end
            if (out_valid && out_ready) begin
                q_data.push_back(out_data); q_gid.push_back(int'(grant_id));
                q_last.push_back(out_last);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (q_data.size() != 7) begin
            errors++; $display("FAIL weights_count: got %0d want 7", q_data.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if ({q_data[i], q_gid[i], q_last[i]} !== {exp_d[i], exp_g[i], exp_l[i]}) begin
                    errors++;
                    $display("FAIL weights_beat%0d: got %h/id%0d/last%0b want %h/id%0d/last%0b",
                             i, q_data[i], q_gid[i], q_last[i], exp_d[i], exp_g[i], exp_l[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int beats = 0;
        do_reset();
        weights = 16'h0020; req_data = 64'h0000_0000_5a5a_0000;
        for (int c = 0; c < 14; c++) begin
            out_ready = !(c >= 2 && c <= 6);
            req_valid = (c <= 7) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            checks++;
            if (obs !== model_out()) begin
                errors++; $display("FAIL backpressure c%0d: got %h want %h", c, obs, model_out());
            end
            if (c >= 2 && c <= 6) begin
                // Held second beat: credit stays at 1, so out_last shows
                checks++;
                if ({out_valid, req_ready[1], out_last} !== 3'b101) begin
                    errors++;
                    $display("FAIL backpressure_hold c%0d: got v%0b r%0b l%0b want v1 r0 l1",
                             c, out_valid, req_ready[1], out_last);
                end
            end
            if (out_valid && out_ready) beats++;
            @(posedge clk); #1;
        end
        checks++;
        if (beats != 2) begin
            errors++; $display("FAIL backpressure_beats: got %0d want 2", beats);
        end
    endtask

    task automatic test_early_drop();
        for (int v = 0; v < 2; v++) begin
            do_reset();
            weights = 16'h0500; req_data = 64'h4444_3333_2222_1111; out_ready = 1'b1;
            req_valid = 4'b0100;
            for (int c = 0; c < 6; c++) begin
                if (c == 3) req_valid = (v == 0) ? 4'b1000 : 4'b0001;
                @(negedge clk);
                checks++;
                if (obs !== model_out()) begin
                    errors++; $display("FAIL early_drop v%0d c%0d: got %h want %h",
                                       v, c, obs, model_out());
                end
                if (c == 4) begin
                    checks++;
                    if (busy !== 1'b0) begin
                        errors++; $display("FAIL early_drop_idle v%0d: got busy=%0b want 0", v, busy);
                    end
                end
                if (c == 5) begin
                    checks++;
                    if ({busy, grant_id} !== {1'b1, (v == 0) ? 2'd3 : 2'd0}) begin
                        errors++; $display("FAIL early_drop_next v%0d: got busy%0b id%0d want busy1 id%0d",
                                           v, busy, grant_id, (v == 0) ? 3 : 0);
                    end
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_skip_idle();
        int            exp_g[3] = '{3, 0, 3};
        logic [N-1:0]  seen_ready = '0;
        do_reset();
        weights = 16'h1111; req_data = 64'haaaa_bbbb_cccc_dddd; out_ready = 1'b1;
        req_valid = 4'b0001;
        for (int c = 0; c < 8; c++) begin
            if (c == 2) begin
                req_valid = 4'b1001;
                q_data.delete(); q_gid.delete(); q_last.delete();
            end
            @(negedge clk);
            checks++;
            if (obs !== model_out()) begin
                errors++; $display("FAIL skip_idle c%0d: got %h want %h", c, obs, model_out());
            end
            seen_ready = seen_ready | req_ready;
            if (c >= 2 && out_valid && out_ready) q_gid.push_back(int'(grant_id));
            @(posedge clk); #1;
        end
        checks++;
        if (seen_ready[2:1] !== 2'b00) begin
            errors++; $display("FAIL skip_idle_ready: got %b want 00", seen_ready[2:1]);
        end
        checks++;
        if (q_gid.size() != 3) begin
            errors++; $display("FAIL skip_idle_count: got %0d want 3", q_gid.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (q_gid[i] != exp_g[i]) begin
                    errors++; $display("FAIL skip_idle_order%0d: got %0d want %0d",
                                       i, q_gid[i], exp_g[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < N; i++) req_valid[i] = ($urandom_range(0, 3) != 0);
            req_data  = {$urandom, $urandom};
            weights   = 16'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            checks++;
            if (obs !== model_out()) begin
                errors++; $display("FAIL random c%0d: got %h want %h", c, obs, model_out());
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_weights();
        test_backpressure();
        test_early_drop();
        test_skip_idle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
